instr_encoder: RTL

Assembles RV32I-subset instruction words from a one-hot instruction type plus operand fields and writes them sequentially into instruction memory over the mem_I write side. It is the inverse of the fetch-stage decoder: it uses the same 23-bit one-hot type vector and 5-bit format vector, so every word it writes decodes back to the type that produced it. Used by test harnesses and the boot loader to build programs in instruction memory.

---
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if : request, memory write and status bundle for instr_encoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] instr_type;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        restart;
  logic        mem_wen_I;
  logic        mem_ready_I;
  logic [31:2] mem_addr_I;
  logic [31:0] mem_wdata_I;
  logic [4:0]  out_format;
  logic [15:0] word_cnt;
  logic        enc_err;

  modport master (
    output in_valid, instr_type, rd, rs1, rs2, imm, restart, mem_ready_I,
    input  in_ready, mem_wen_I, mem_addr_I, mem_wdata_I, out_format, word_cnt, enc_err
  );

  modport slave (
    input  in_valid, instr_type, rd, rs1, rs2, imm, restart, mem_ready_I,
    output in_ready, mem_wen_I, mem_addr_I, mem_wdata_I, out_format, word_cnt, enc_err
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder : RV32I-subset word assembler writing sequentially to imem
// Optional checking: INSTR_ENCODER_CHECK_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [4:0]  FMT_J = 5'b00001;
  localparam logic [4:0]  FMT_B = 5'b00010;
  localparam logic [4:0]  FMT_S = 5'b00100;
  localparam logic [4:0]  FMT_I = 5'b01000;
  localparam logic [4:0]  FMT_R = 5'b10000;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [31:0] word;
  logic [4:0]  fmt;
  logic        wen;
  logic [31:2] addr;
  logic [15:0] cnt;

  logic [4:0]  sel;
  logic        any;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  cls;
  logic        shamt;
  logic [31:0] enc_word;
  logic [4:0]  enc_fmt;
  logic        range_ok;
  logic [31:0] final_word;
  logic [4:0]  final_fmt;

  logic accept;
  logic complete;

  assign bus.in_ready = !bus.restart && (!wen || bus.mem_ready_I);
  assign accept       = bus.in_valid && bus.in_ready;
  assign complete     = wen && bus.mem_ready_I;

  // Highest set bit of the type vector selects the instruction.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = 0; i < 23; i++) begin
      if (bus.instr_type[i]) begin
        sel = 5'(i);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    op    = OP_R;
    f3    = 3'b000;
    f7    = 7'b0000000;
    cls   = FMT_R;
    shamt = 1'b0;
    case (sel)
      5'd22: begin cls = FMT_J; op = OP_JAL; end
      5'd21: begin cls = FMT_I; op = OP_JALR; end
      5'd20: begin cls = FMT_B; op = OP_BR; end
      5'd19: begin cls = FMT_B; op = OP_BR; f3 = 3'b001; end
      5'd18: begin cls = FMT_I; op = OP_LOAD; f3 = 3'b010; end
      5'd17: begin cls = FMT_S; op = OP_STORE; f3 = 3'b010; end
      5'd16: begin cls = FMT_I; op = OP_IMM; end
      5'd15: begin cls = FMT_I; op = OP_IMM; f3 = 3'b010; end
      5'd14: begin cls = FMT_I; op = OP_IMM; f3 = 3'b100; end
      5'd13: begin cls = FMT_I; op = OP_IMM; f3 = 3'b110; end
      5'd12: begin cls = FMT_I; op = OP_IMM; f3 = 3'b111; end
      5'd11: begin cls = FMT_I; op = OP_IMM; f3 = 3'b001; shamt = 1'b1; end
      5'd10: begin cls = FMT_I; op = OP_IMM; f3 = 3'b101; shamt = 1'b1; end
      5'd9:  begin cls = FMT_I; op = OP_IMM; f3 = 3'b101; shamt = 1'b1; f7 = F7_ALT; end
      5'd8:  f3 = 3'b000;
      5'd7:  f7 = F7_ALT;
      5'd6:  f3 = 3'b001;
      5'd5:  f3 = 3'b010;
      5'd4:  f3 = 3'b100;
      5'd3:  f3 = 3'b101;
      5'd2:  begin f3 = 3'b101; f7 = F7_ALT; end
      5'd1:  f3 = 3'b110;
      default: f3 = 3'b111;
    endcase
  end

  logic i_ok, b_ok, j_ok, sh_ok;
  assign i_ok  = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
  assign b_ok  = ((&bus.imm[31:12]) || !(|bus.imm[31:12])) && !bus.imm[0];
  assign j_ok  = ((&bus.imm[31:20]) || !(|bus.imm[31:20])) && !bus.imm[0];
  assign sh_ok = !(|bus.imm[31:5]);

  always_comb begin
    enc_word = NOP;
    enc_fmt  = FMT_I;
    range_ok = 1'b1;
    if (any) begin
      enc_fmt = cls;
      case (cls)
        FMT_R: enc_word = {f7, bus.rs2, bus.rs1, f3, bus.rd, op};
        FMT_I: begin
          if (shamt) begin
            enc_word = {f7, bus.imm[4:0], bus.rs1, f3, bus.rd, op};
            range_ok = sh_ok;
          end else begin
            enc_word = {bus.imm[11:0], bus.rs1, f3, bus.rd, op};
            range_ok = i_ok;
          end
        end
        FMT_S: begin
          enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, f3, bus.imm[4:0], op};
          range_ok = i_ok;
        end
        FMT_B: begin
          enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, f3,
                      bus.imm[4:1], bus.imm[11], op};
          range_ok = b_ok;
        end
        FMT_J: begin
          enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, op};
          range_ok = j_ok;
        end
        default: enc_word = NOP;
      endcase
    end
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic onehot;
  logic bad;
  logic err;

  assign onehot     = any && ((bus.instr_type & (bus.instr_type - 23'd1)) == 23'd0);
  assign bad        = !onehot || !range_ok;
  assign final_word = bad ? NOP : enc_word;
  assign final_fmt  = bad ? FMT_I : enc_fmt;

  always_ff @(posedge clk) begin
    if (rst || bus.restart) begin
      err <= 1'b0;
    end else if (accept && bad) begin
      err <= 1'b1;
    end
  end

  assign bus.enc_err = err;
`else
  assign final_word  = enc_word;
  assign final_fmt   = enc_fmt;
  assign bus.enc_err = 1'b0;

  logic unused_range;
  assign unused_range = &{1'b0, range_ok};
`endif

  // restart outranks a same-cycle completion; in_ready is low so no accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      fmt  <= '0;
      wen  <= 1'b0;
      addr <= BASE_ADDR[31:2];
      cnt  <= '0;
    end else if (bus.restart) begin
      wen  <= 1'b0;
      addr <= BASE_ADDR[31:2];
      cnt  <= '0;
    end else begin
      if (complete) begin
        addr <= addr + 30'd1;
        cnt  <= cnt + 16'd1;
      end
      if (accept) begin
        word <= final_word;
        fmt  <= final_fmt;
        wen  <= 1'b1;
      end else if (complete) begin
        wen  <= 1'b0;
      end
    end
  end

  assign bus.mem_wen_I   = wen;
  assign bus.mem_addr_I  = addr;
  assign bus.mem_wdata_I = word;
  assign bus.out_format  = fmt;
  assign bus.word_cnt    = cnt;

endmodule

`default_nettype wire
